// File: rtl/fifo_read_ctrl.sv
// FIFO read-side controller.
// Brings the Gray-coded write pointer into the read clock domain through a
// two-flop synchronizer. Keeps the binary read pointer and exports it in Gray
// form. Produces registered empty, almost_empty and occupancy flags computed
// from the pointer value that is about to be registered, so the flags are never
// one read behind. Also keeps a sticky underflow flag.
module fifo_read_ctrl #(
  parameter int Address   = 2,
  parameter int AE_THRESH = 1
) (
  input  logic               r_clk,
  input  logic               r_rst_n,
  input  logic               r_en,
  input  logic [Address:0]   w_gptr,
  output logic               r_fire,
  output logic [Address-1:0] r_addr,
  output logic [Address:0]   r_gptr,
  output logic               empty,
  output logic               almost_empty,
  output logic [Address:0]   r_level,
  output logic               underflow
);

  // almost_empty threshold at pointer width (0 .. 2**Address fits in Address+1 bits)
  localparam logic [Address:0] AE_LIM = (Address+1)'(AE_THRESH);

  // Binary to Gray: adjacent pointer values differ in exactly one bit
  function automatic logic [Address:0] bin2gray(input logic [Address:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it
  function automatic logic [Address:0] gray2bin(input logic [Address:0] g);
    logic [Address:0] b;
    b[Address] = g[Address];
    for (int i = Address - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [Address:0] r_wq1;
  logic [Address:0] r_wq2;
  logic [Address:0] r_bin;

  logic [Address:0] w_bin_s;
  logic             w_fire;
  logic [Address:0] w_bin_next;
  logic [Address:0] w_gray_next;
  logic [Address:0] w_level_next;

  // A read is accepted only when the FIFO is not empty. This strobe also
  // drives the memory read enable.
  assign w_fire = r_en & ~empty;
  assign r_fire = w_fire;

  // Next read pointer and its Gray form. Both the exported pointer and the
  // flags are computed from this next value.
  assign w_bin_next  = r_bin + {{Address{1'b0}}, w_fire};
  assign w_gray_next = bin2gray(w_bin_next);

  // Synchronized write pointer in binary. The occupancy wraps modulo
  // 2**(Address+1), so the pointer MSB tells a full wrap apart from empty.
  assign w_bin_s      = gray2bin(r_wq2);
  assign w_level_next = w_bin_s - w_bin_next;

  // The memory address is the low part of the binary read pointer
  assign r_addr = r_bin[Address-1:0];

  // Two-flop synchronizer. This is the only logic that samples w_gptr.
  always_ff @(posedge r_clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      r_wq1 <= {(Address+1){1'b0}};
      r_wq2 <= {(Address+1){1'b0}};
    end else begin
      r_wq1 <= w_gptr;
      r_wq2 <= r_wq1;
    end
  end

  // Read pointer, exported Gray pointer and look-ahead status flags
  always_ff @(posedge r_clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      r_bin        <= {(Address+1){1'b0}};
      r_gptr       <= {(Address+1){1'b0}};
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      r_level      <= {(Address+1){1'b0}};
    end else begin
      r_bin        <= w_bin_next;
      r_gptr       <= w_gray_next;
      empty        <= (w_gray_next == r_wq2);
      almost_empty <= (w_level_next <= AE_LIM);
      r_level      <= w_level_next;
    end
  end

  // Sticky underflow: set when a read is attempted while empty; only reset clears it
  always_ff @(posedge r_clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      underflow <= 1'b0;
    end else begin
      underflow <= underflow | (r_en & empty);
    end
  end

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Bench for fifo_read_ctrl (Address=2, AE_THRESH=1).
// The reference model tracks the pointers as plain integers modulo 8. It holds
// the synchronizer as a two-entry delay of the write-pointer count, and it
// derives the flags from the occupancy arithmetic.
module tb_fifo_read_ctrl;

  localparam int ADDR = 2;
  localparam int AE   = 1;
  localparam int PMOD = 8;   // 2**(ADDR+1)

  logic            r_clk;
  logic            r_rst_n;
  logic            r_en;
  logic [ADDR:0]   w_gptr;
  logic            r_fire;
  logic [ADDR-1:0] r_addr;
  logic [ADDR:0]   r_gptr;
  logic            empty;
  logic            almost_empty;
  logic [ADDR:0]   r_level;
  logic            underflow;

  logic [ADDR:0]   w_bin_drv;

  int n_checks;
  int n_fails;

  // reference model state
  int  m_ws1, m_ws2, m_rbin, m_level;
  bit  m_empty, m_ae, m_under;

  fifo_read_ctrl #(.Address(ADDR), .AE_THRESH(AE)) dut (
    .r_clk(r_clk), .r_rst_n(r_rst_n), .r_en(r_en), .w_gptr(w_gptr),
    .r_fire(r_fire), .r_addr(r_addr), .r_gptr(r_gptr), .empty(empty),
    .almost_empty(almost_empty), .r_level(r_level), .underflow(underflow)
  );

  assign w_gptr = w_bin_drv ^ (w_bin_drv >> 1);

  initial r_clk = 1'b0;
  always #5 r_clk = ~r_clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int gray_of(input int b);
    return (b ^ (b >> 1)) % PMOD;
  endfunction

  task automatic model_reset();
    m_ws1 = 0; m_ws2 = 0; m_rbin = 0; m_level = 0;
    m_empty = 1'b1; m_ae = 1'b1; m_under = 1'b0;
  endtask

  // one rising edge of the read domain, in terms of pointer counts
  task automatic model_step();
    int fire, nxt;
    fire = (r_en && m_empty == 1'b0) ? 1 : 0;
    if (r_en && m_empty) m_under = 1'b1;
    nxt     = (m_rbin + fire) % PMOD;
    m_level = (m_ws2 - nxt + PMOD) % PMOD;
    m_empty = (m_level == 0);
    m_ae    = (m_level <= AE);
    m_ws2   = m_ws1;
    m_ws1   = int'(w_bin_drv);
    m_rbin  = nxt;
  endtask

  task automatic check_outputs();
    check_val("r_fire",       r_fire,       (r_en && !m_empty) ? 1 : 0);
    check_val("empty",        empty,        m_empty);
    check_val("almost_empty", almost_empty, m_ae);
    check_val("r_level",      r_level,      m_level);
    check_val("r_gptr",       r_gptr,       gray_of(m_rbin));
    check_val("r_addr",       r_addr,       m_rbin % 4);
    check_val("underflow",    underflow,    m_under);
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_empty"},     empty,        1);
    check_val({tag, "_ae"},        almost_empty, 1);
    check_val({tag, "_addr"},      r_addr,       0);
    check_val({tag, "_gptr"},      r_gptr,       0);
    check_val({tag, "_level"},     r_level,      0);
    check_val({tag, "_underflow"}, underflow,    0);
  endtask

  // check at the falling edge, then advance the model on the rising edge
  task automatic cycle();
    @(negedge r_clk);
    check_outputs();
    @(posedge r_clk);
    if (r_rst_n) model_step();
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    r_rst_n  = 1'b0;
    r_en     = 1'b0;
    w_bin_drv = '0;
    model_reset();
    repeat (2) @(posedge r_clk);
    #1;
    check_reset_vals("por");
    r_rst_n = 1'b1;
    cycle();

    // single write: empty falls on the third edge
    w_bin_drv = 3'd1;
    repeat (3) cycle();
    check_val("single_empty", empty, 0);
    check_val("single_level", r_level, 1);
    check_val("single_ae",    almost_empty, 1);

    // drain a full FIFO, fifth read underflows
    w_bin_drv = 3'd4;
    repeat (3) cycle();
    check_val("full_level", r_level, 4);
    r_en = 1'b1;
    repeat (5) cycle();
    r_en = 1'b0;
    check_val("drain_gptr",      r_gptr, 3'b110);
    check_val("drain_empty",     empty, 1);
    check_val("drain_underflow", underflow, 1);
    cycle();

    // wrap: write pointer reaches 8 (== 0), drain 4 more
    w_bin_drv = 3'd0;
    repeat (3) cycle();
    check_val("wrap_level", r_level, 4);
    r_en = 1'b1;
    repeat (4) cycle();
    r_en = 1'b0;
    check_val("wrap_gptr",  r_gptr, 3'b000);
    check_val("wrap_empty", empty, 1);
    check_val("wrap_level0", r_level, 0);
    cycle();

    // simultaneous read and write-pointer advance
    w_bin_drv = 3'd1; cycle();
    w_bin_drv = 3'd2; repeat (4) cycle();
    check_val("simul_pre_level", r_level, 2);
    w_bin_drv = 3'd3;
    repeat (2) cycle();
    r_en = 1'b1;
    cycle();
    r_en = 1'b0;
    check_val("simul_level", r_level, 2);
    check_val("simul_empty", empty, 0);

    // randomized traffic; the writer never runs more than a full FIFO ahead
    for (int i = 0; i < 400; i++) begin
      r_en = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) != 0 &&
          ((int'(w_bin_drv) - m_rbin + PMOD) % PMOD) < 4)
        w_bin_drv = w_bin_drv + 3'd1;
      cycle();
    end

    // drain, then build occupancy 3 and reset mid-clock
    w_bin_drv = 3'(m_ws1);
    r_en = 1'b1;
    for (int i = 0; i < 12 && !(m_empty && m_ws1 == int'(w_bin_drv) && m_ws2 == m_ws1); i++) cycle();
    r_en = 1'b0;
    check_val("drain_to_empty", empty, 1);
    for (int i = 0; i < 3; i++) begin
      w_bin_drv = w_bin_drv + 3'd1;
      cycle();
    end
    repeat (3) cycle();
    check_val("pre_reset_level", r_level, 3);
    #2;
    r_rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_vals("mid_reset");
    repeat (2) cycle();
    r_rst_n = 1'b1;
    repeat (5) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
